// File: rtl/ab_seq_driver_pkg.sv
// Shared constants for AB flip-flop command producers.
// AB excitation codes and driver FSM state encodings.
package ab_seq_driver_pkg;

    localparam logic [1:0] AB_HOLD = 2'b00;
    localparam logic [1:0] AB_SET  = 2'b01;
    localparam logic [1:0] AB_RST  = 2'b10;
    localparam logic [1:0] AB_TOG  = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

endpackage

// File: rtl/ab_excite.sv
// Combinational AB excitation: command that moves Q from q_model to target.
// Reusable by any AB-flop producer.
module ab_excite
    import ab_seq_driver_pkg::*;
(
    input  logic       target,
    input  logic       q_model,
    input  logic       use_toggle,
    output logic [1:0] ab
);

    always_comb begin
        ab = AB_HOLD;
        if (target != q_model) begin
            if (use_toggle)
                ab = AB_TOG;
            else
                ab = target ? AB_SET : AB_RST;
        end
    end

endmodule

// File: rtl/ab_seq_driver.sv
// Drives an AB flop bit by bit so its Q reproduces a loaded pattern,
// tracking a model of Q and flagging divergence from the fed-back Q.
module ab_seq_driver
    import ab_seq_driver_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int USE_TOGGLE = 0,
    parameter int LSB_FIRST  = 1,
    localparam int IW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] pattern,
    output logic             ready,
    output logic             busy,
    output logic             A,
    output logic             B,
    input  logic             q_fb,
    output logic [IW-1:0]    bit_idx,
    output logic             done,
    output logic             mismatch
);

    logic [1:0]       state;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_next;
    logic [IW-1:0]    cnt;
    logic             q_model;
    logic             t_cur;
    logic             t_nxt;
    logic             t_first;
    logic [1:0]       ab_load;
    logic [1:0]       ab_next;
    logic             last;
    logic             cmp;

    function automatic logic front(input logic [WIDTH-1:0] x);
        return (LSB_FIRST != 0) ? x[0] : x[WIDTH-1];
    endfunction

    assign sh_next = (LSB_FIRST != 0) ? (sh >> 1) : (sh << 1);
    assign t_cur   = front(sh);
    assign t_nxt   = front(sh_next);
    assign t_first = front(pattern);
    assign last    = (cnt == IW'(WIDTH - 1));

    // q_model is committed at the edge before, so it is what the flop now holds
    assign cmp = ((state == S_DRIVE) && (cnt != '0)) || (state == S_CHECK);

    ab_excite u_ex_load (
        .target     (t_first),
        .q_model    (q_model),
        .use_toggle (1'(USE_TOGGLE)),
        .ab         (ab_load)
    );

    // Next bit is encoded against the bit being committed at this edge
    ab_excite u_ex_next (
        .target     (t_nxt),
        .q_model    (t_cur),
        .use_toggle (1'(USE_TOGGLE)),
        .ab         (ab_next)
    );

    assign ready   = (state == S_IDLE);
    assign busy    = (state == S_DRIVE) || (state == S_CHECK);
    assign done    = (state == S_CHECK);
    assign bit_idx = (state == S_DRIVE) ? cnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            sh       <= '0;
            cnt      <= '0;
            q_model  <= 1'b0;
            A        <= 1'b0;
            B        <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            if (cmp && (q_fb != q_model))
                mismatch <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (load) begin
                        state    <= S_DRIVE;
                        sh       <= pattern;
                        cnt      <= '0;
                        mismatch <= 1'b0;
                        {A, B}   <= ab_load;
                    end
                end
                S_DRIVE: begin
                    q_model <= t_cur;
                    sh      <= sh_next;
                    if (last) begin
                        state  <= S_CHECK;
                        cnt    <= '0;
                        {A, B} <= AB_HOLD;
                    end else begin
                        cnt    <= cnt + IW'(1);
                        {A, B} <= ab_next;
                    end
                end
                S_CHECK: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ab_seq_driver.sv
// Bench: two drivers (set/reset and toggle encodings) each feeding an AB flop;
// expected AB/index/Q sequences are queued on load and consumed by monitors.
module tb_ab_seq_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load0 = 1'b0, load1 = 1'b0;
    logic [3:0] pat0 = '0, pat1 = '0;
    logic       ready0, busy0, a0, b0, done0, mm0;
    logic       ready1, busy1, a1, b1, done1, mm1;
    logic [1:0] idx0, idx1;
    logic       q0, q1;
    logic       force0 = 1'b0;
    logic       qfb0, qfb1;

    int n_chk = 0;
    int n_err = 0;
    int ndone0 = 0, ndone1 = 0;
    logic m_q0 = 1'b0, m_q1 = 1'b0;
    logic pend0 = 1'b0, pend1 = 1'b0;

    logic [3:0] sb_ab0[$], sb_ab1[$];
    logic       sb_q0[$], sb_q1[$];

    always #5 clk = ~clk;

    assign qfb0 = force0 ? 1'b0 : q0;
    assign qfb1 = q1;

    ab_seq_driver #(.WIDTH(4), .USE_TOGGLE(0), .LSB_FIRST(1)) u0 (
        .clk(clk), .rst_n(rst_n), .load(load0), .pattern(pat0),
        .ready(ready0), .busy(busy0), .A(a0), .B(b0), .q_fb(qfb0),
        .bit_idx(idx0), .done(done0), .mismatch(mm0)
    );

    ab_seq_driver #(.WIDTH(4), .USE_TOGGLE(1), .LSB_FIRST(1)) u1 (
        .clk(clk), .rst_n(rst_n), .load(load1), .pattern(pat1),
        .ready(ready1), .busy(busy1), .A(a1), .B(b1), .q_fb(qfb1),
        .bit_idx(idx1), .done(done1), .mismatch(mm1)
    );

    // Downstream AB flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q0 <= 1'b0;
        else case ({a0, b0})
            2'b01: q0 <= 1'b1;
            2'b10: q0 <= 1'b0;
            2'b11: q0 <= ~q0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q1 <= 1'b0;
        else case ({a1, b1})
            2'b01: q1 <= 1'b1;
            2'b10: q1 <= 1'b0;
            2'b11: q1 <= ~q1;
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int which, input logic [3:0] p);
        logic t;
        logic [1:0] cmd;
        for (int i = 0; i < 4; i++) begin
            t = p[i];
            if (which == 0) begin
                cmd = (t == m_q0) ? 2'b00 : (t ? 2'b01 : 2'b10);
                sb_ab0.push_back({2'(i), cmd});
                sb_q0.push_back(t);
                m_q0 = t;
            end else begin
                cmd = (t == m_q1) ? 2'b00 : 2'b11;
                sb_ab1.push_back({2'(i), cmd});
                sb_q1.push_back(t);
                m_q1 = t;
            end
        end
    endtask

    // Monitor 0: Q after each captured bit, then AB/index of the current bit
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend0 = 1'b0;
            sb_ab0.delete();
            sb_q0.delete();
        end else begin
            if (pend0) begin
                if (sb_q0.size() == 0) check("q0_underflow", 0, 1);
                else check("q0", 32'(q0), 32'(sb_q0.pop_front()));
            end
            pend0 = busy0 && !done0;
            if (busy0 && !done0) begin
                if (sb_ab0.size() == 0) check("ab0_underflow", 0, 1);
                else check("idx_ab0", {idx0, a0, b0}, 32'(sb_ab0.pop_front()));
            end
            if (done0) ndone0++;
        end
    end

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend1 = 1'b0;
            sb_ab1.delete();
            sb_q1.delete();
        end else begin
            if (pend1) begin
                if (sb_q1.size() == 0) check("q1_underflow", 0, 1);
                else check("q1", 32'(q1), 32'(sb_q1.pop_front()));
            end
            pend1 = busy1 && !done1;
            if (busy1 && !done1) begin
                if (sb_ab1.size() == 0) check("ab1_underflow", 0, 1);
                else check("idx_ab1", {idx1, a1, b1}, 32'(sb_ab1.pop_front()));
            end
            if (done1) ndone1++;
        end
    end

    task automatic do_load(input int which, input logic [3:0] p);
        if (which == 0) begin
            pat0 = p; load0 = 1'b1;
        end else begin
            pat1 = p; load1 = 1'b1;
        end
        push_exp(which, p);
        @(posedge clk);
        #1;
        load0 = 1'b0;
        load1 = 1'b0;
    endtask

    task automatic wait_done(input int which);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((which == 0) ? done0 : done1) break;
        end
        check("done_seen", 32'(k < 20), 1);
    endtask

    initial begin
        int e;
        #3;
        check("rst_ready", ready0, 1);
        check("rst_busy", busy0, 0);
        check("rst_ab", {a0, b0}, 0);
        check("rst_done", done0, 0);
        check("rst_mm", mm0, 0);
        check("rst_idx", idx0, 0);
        #9 rst_n = 1'b1;
        @(negedge clk); #1;

        // 1: set/reset encoding of 1011
        do_load(0, 4'b1011);
        wait_done(0);
        check("t1_mm", mm0, 0);
        @(negedge clk); #1;
        check("t1_ready", ready0, 1);
        check("t1_ndone", ndone0, 1);
        check("t1_q", q0, 1);

        // 2: toggle encoding of 1011
        do_load(1, 4'b1011);
        wait_done(1);
        check("t2_mm", mm1, 0);
        @(negedge clk); #1;
        check("t2_ndone", ndone1, 1);
        check("t2_q", q1, 1);

        // 3: 0000 from Q=1, ready six edges after the load edge
        do_load(0, 4'b0000);
        e = 1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (ready0) break;
        end
        check("t3_edges", e, 6);
        check("t3_q", q0, 0);
        check("t3_ndone", ndone0, 2);
        #1;

        // 4: forced feedback, sticky mismatch, cleared by next load
        force0 = 1'b1;
        do_load(0, 4'b0001);
        check("t4_mm_early", mm0, 0);
        repeat (3) @(negedge clk);
        check("t4_mm_set", mm0, 1);
        wait_done(0);
        check("t4_mm_done", mm0, 1);
        @(negedge clk); #1;
        force0 = 1'b0;
        check("t4_mm_idle", mm0, 1);
        do_load(0, 4'b0000);
        check("t4_mm_clr", mm0, 0);
        wait_done(0);
        check("t4_mm_end", mm0, 0);
        @(negedge clk); #1;

        // 5: reset during bit 2
        do_load(0, 4'b1011);
        repeat (3) @(negedge clk);
        check("t5_idx_pre", idx0, 2);
        #1 rst_n = 1'b0;
        #1;
        check("t5_ab", {a0, b0}, 0);
        check("t5_busy", busy0, 0);
        check("t5_ready", ready0, 1);
        check("t5_q", q0, 0);
        check("t5_idx", idx0, 0);
        #2 rst_n = 1'b1;
        m_q0 = 1'b0;
        m_q1 = 1'b0;
        @(negedge clk); #1;
        do_load(0, 4'b0110);
        wait_done(0);
        check("t5_mm", mm0, 0);
        @(negedge clk); #1;

        // 6: load while busy is ignored
        do_load(0, 4'b0101);
        pat0 = 4'b1111;
        load0 = 1'b1;
        @(posedge clk); #1;
        load0 = 1'b0;
        wait_done(0);
        @(negedge clk); #1;
        check("t6_ready", ready0, 1);
        repeat (2) @(negedge clk);
        check("t6_busy", busy0, 0);
        check("t6_q", q0, 0);

        check("sb_ab0_empty", sb_ab0.size(), 0);
        check("sb_q0_empty", sb_q0.size(), 0);
        check("sb_ab1_empty", sb_ab1.size(), 0);
        check("sb_q1_empty", sb_q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
